// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage requestor and the data-memory
// responder. The requestor presents one word request and holds it while stall=1.
// The responder returns a one-cycle done pulse with rd_data or an err flag.
interface dmem_responder_if;
    logic        req_en;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        stall;
    logic        done;
    logic [15:0] rd_data;
    logic        err;

    modport master (
        output req_en, req_wr, req_addr, req_data,
        input  stall, done, rd_data, err
    );

    modport slave (
        input  req_en, req_wr, req_addr, req_data,
        output stall, done, rd_data, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM-stage load/store port.
// It takes one word request at a time and stalls the requestor for LATENCY
// cycles. It then pulses done for one cycle, with load data or an alignment
// error. Storage is 2^ADDR_BITS 16-bit words, byte-addressed, and the address
// wraps above the array size.
module dmem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic       SINGLE   = (LATENCY == 1);

    state_t                state_q,   state_d;
    logic [3:0]            cnt_q,     cnt_d;
    logic [ADDR_BITS-1:0]  addr_q,    addr_d;
    logic [15:0]           data_q,    data_d;
    logic                  wr_q,      wr_d;
    logic                  mis_q,     mis_d;
    logic                  done_q,    done_d;
    logic                  err_q,     err_d;
    logic [15:0]           rd_data_q, rd_data_d;

    logic [15:0]           mem [DEPTH];

    logic                  can_accept;
    logic                  accept;
    logic                  req_mis;
    logic                  req_short;
    logic [ADDR_BITS-1:0]  req_idx;
    logic                  enter_resp;
    logic                  mem_we;
    logic                  unused_addr_bits;

    // Address bits above the array are ignored, so the address wraps.
    assign req_idx          = bus.req_addr[ADDR_BITS:1];
    assign unused_addr_bits = ^bus.req_addr[15:ADDR_BITS+1];
    assign req_mis          = bus.req_addr[0];

    // A misaligned request, or any request in a single-cycle build, goes to
    // RESP on the edge where it is accepted. So it never stalls the requestor.
    assign req_short  = req_mis | SINGLE;
    assign can_accept = (state_q == IDLE) || (state_q == RESP);
    assign accept     = can_accept & bus.req_en;

    assign bus.stall   = (state_q == BUSY) | (accept & ~req_short);
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rd_data = rd_data_q;

    // Next-state logic: accept a new request, count down while busy, drop back to idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        mis_d   = mis_q;

        if (accept) begin
            addr_d = req_idx;
            data_d = bus.req_data;
            wr_d   = bus.req_wr;
            mis_d  = req_mis;
            if (req_short) begin
                state_d = RESP;
            end else begin
                state_d = BUSY;
                cnt_d   = CNT_INIT;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Response values are prepared on the edge that enters RESP.
    // The *_d values give the transaction that is completing, whether it was
    // latched earlier or accepted on this same edge.
    always_comb begin
        enter_resp = (state_d == RESP);
        mem_we     = enter_resp & wr_d & ~mis_d & ~rst;
        done_d     = enter_resp;
        err_d      = enter_resp & mis_d;
        rd_data_d  = rd_data_q;
        if (enter_resp) begin
            rd_data_d = (!wr_d && !mis_d) ? mem[addr_d] : 16'h0000;
        end
    end

    // State and response registers, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments, so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    // The request latches only take meaningful values once a request is
    // accepted, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        wr_q   <= wr_d;
        mis_q  <= mis_d;
    end

    // Store commit on the edge that enters RESP. A load accepted in that RESP
    // cycle therefore reads the new value.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset, so it maps onto RAM and keeps its contents across rst.
        if (mem_we) begin
            mem[addr_d] <= data_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Instance u_dut uses LATENCY=4 and
// runs the table vectors plus the reset corner cases. Instance u_dut1 uses
// LATENCY=1 and runs an alternating store/load stream.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus1 ();

    dmem_responder #(.ADDR_BITS(8), .LATENCY(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // One clock cycle of stimulus, with the outputs expected in that cycle.
    typedef struct {
        string       name;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic        stall;
        logic        done;
        logic        err;
        logic [15:0] rd;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_row(input string name, input logic en, input logic wr,
                                    input logic [15:0] addr, input logic [15:0] data,
                                    input logic stall, input logic done, input logic err,
                                    input logic [15:0] rd);
        vec_t v;
        v.name  = name;
        v.en    = en;
        v.wr    = wr;
        v.addr  = addr;
        v.data  = data;
        v.stall = stall;
        v.done  = done;
        v.err   = err;
        v.rd    = rd;
        vq.push_back(v);
    endfunction

    // An aligned request held for 4 cycles under stall. The first cycle may be
    // the RESP cycle of the previous request (pd/pe/prd).
    function automatic void add_req(input string name, input logic wr, input logic [15:0] addr,
                                    input logic [15:0] data, input logic pd, input logic pe,
                                    input logic [15:0] prd);
        add_row(name, 1'b1, wr, addr, data, 1'b1, pd, pe, prd);
        for (int i = 1; i < 4; i++) begin
            add_row(name, 1'b1, wr, addr, data, 1'b1, 1'b0, 1'b0, 16'h0000);
        end
    endfunction

    function automatic void add_idle(input string name, input logic pd, input logic pe,
                                     input logic [15:0] prd);
        add_row(name, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, pd, pe, prd);
    endfunction

    // Issue one load on the LATENCY=4 instance. Wait a bounded time for done,
    // then check the observed latency and the returned data.
    task automatic do_load(input string name, input logic [15:0] addr, input logic [15:0] exp_rd);
        int          lat;
        logic        seen;
        logic [15:0] got;
        lat  = 0;
        seen = 1'b0;
        got  = 16'h0000;
        @(negedge clk);
        bus.req_en   = 1'b1;
        bus.req_wr   = 1'b0;
        bus.req_addr = addr;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            bus.req_en = 1'b0;
            #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = c;
                got  = bus.rd_data;
            end
        end
        check({name, " done seen"}, 16'(seen), 16'd1);
        check({name, " latency"}, 16'(lat), 16'd4);
        check({name, " rd_data"}, got, exp_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;

        bus.req_en    = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_data  = 16'h0000;
        bus1.req_en   = 1'b0;
        bus1.req_wr   = 1'b0;
        bus1.req_addr = 16'h0000;
        bus1.req_data = 16'h0000;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset stall",   16'(bus.stall), 16'd0);
        check("reset done",    16'(bus.done),  16'd0);
        check("reset err",     16'(bus.err),   16'd0);
        check("reset rd_data", bus.rd_data,    16'h0000);
        check("reset done L1", 16'(bus1.done), 16'd0);

        // Store then load
        add_req ("st_beef",      1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 16'h0000);
        add_idle("st_beef_resp", 1'b1, 1'b0, 16'h0000);
        add_req ("ld_beef",      1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000);
        add_idle("ld_beef_resp", 1'b1, 1'b0, 16'hBEEF);
        // Back-to-back: a load accepted in the RESP cycle of the store
        add_req ("st_cafe",      1'b1, 16'h0030, 16'hCAFE, 1'b0, 1'b0, 16'h0000);
        add_req ("b2b_ld",       1'b0, 16'h0030, 16'h0000, 1'b1, 1'b0, 16'h0000);
        add_idle("b2b_ld_resp",  1'b1, 1'b0, 16'hCAFE);
        // Misaligned load, then a misaligned store accepted in its RESP cycle
        add_row ("mis_ld",       1'b1, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
        add_row ("mis_st",       1'b1, 1'b1, 16'h0011, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h0000);
        add_req ("ld_after_mis", 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0000);
        add_idle("ld_after_mis_resp", 1'b1, 1'b0, 16'hBEEF);
        // Address wrap: 0x0202 aliases word 1 (0x0002)
        add_req ("st_wrap",      1'b1, 16'h0002, 16'h1357, 1'b0, 1'b0, 16'h0000);
        add_idle("st_wrap_resp", 1'b1, 1'b0, 16'h0000);
        add_req ("ld_wrap",      1'b0, 16'h0202, 16'h0000, 1'b0, 1'b0, 16'h0000);
        add_idle("ld_wrap_resp", 1'b1, 1'b0, 16'h1357);
        // Preload word 0x0020 for the reset test
        add_req ("st_aaaa",      1'b1, 16'h0020, 16'hAAAA, 1'b0, 1'b0, 16'h0000);
        add_idle("st_aaaa_resp", 1'b1, 1'b0, 16'h0000);
        add_idle("quiet",        1'b0, 1'b0, 16'h0000);

        foreach (vq[i]) begin
            @(negedge clk);
            bus.req_en   = vq[i].en;
            bus.req_wr   = vq[i].wr;
            bus.req_addr = vq[i].addr;
            bus.req_data = vq[i].data;
            #1;
            check({vq[i].name, " stall"}, 16'(bus.stall), 16'(vq[i].stall));
            check({vq[i].name, " done"},  16'(bus.done),  16'(vq[i].done));
            check({vq[i].name, " err"},   16'(bus.err),   16'(vq[i].err));
            if (vq[i].done) begin
                check({vq[i].name, " rd_data"}, bus.rd_data, vq[i].rd);
            end
        end

        // Reset during BUSY: the store of 0x5555 must be dropped
        @(negedge clk);
        bus.req_en   = 1'b1;
        bus.req_wr   = 1'b1;
        bus.req_addr = 16'h0020;
        bus.req_data = 16'h5555;
        #1;
        check("rst_mid stall T", 16'(bus.stall), 16'd1);
        @(negedge clk);
        #1;
        check("rst_mid stall T+1", 16'(bus.stall), 16'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        bus.req_en = 1'b0;
        #1;
        check("rst_mid stall after", 16'(bus.stall), 16'd0);
        check("rst_mid done after",  16'(bus.done),  16'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (bus.done === 1'b1) pulses++;
        end
        check("rst_mid no done pulse", 16'(pulses), 16'd0);
        do_load("rst_mid readback", 16'h0020, 16'hAAAA);

        // Simultaneous rst and misaligned request: the reset wins
        @(negedge clk);
        rst          = 1'b1;
        bus.req_en   = 1'b1;
        bus.req_wr   = 1'b0;
        bus.req_addr = 16'h0021;
        @(negedge clk);
        rst        = 1'b0;
        bus.req_en = 1'b0;
        #1;
        check("rst_req done", 16'(bus.done),  16'd0);
        check("rst_req stall", 16'(bus.stall), 16'd0);
        @(negedge clk);
        #1;
        check("rst_req done later", 16'(bus.done), 16'd0);

        // LATENCY=1: alternating store/load every cycle
        for (int k = 0; k <= 8; k++) begin
            logic [15:0] exp_rd;
            @(negedge clk);
            if (k < 8) begin
                bus1.req_en   = 1'b1;
                bus1.req_wr   = (k % 2 == 0);
                bus1.req_addr = 16'(16'h0100 + 2 * (k - (k % 2)));
                bus1.req_data = 16'(16'h1000 + 16'h0111 * k);
            end else begin
                bus1.req_en = 1'b0;
            end
            #1;
            check($sformatf("l1 stall k=%0d", k), 16'(bus1.stall), 16'd0);
            if (k > 0) begin
                // Request k-1 completes now: a store returns 0, and a load
                // returns the data of the store at k-2.
                exp_rd = ((k - 1) % 2 == 0) ? 16'h0000 : 16'(16'h1000 + 16'h0111 * (k - 2));
                check($sformatf("l1 done k=%0d", k), 16'(bus1.done), 16'd1);
                check($sformatf("l1 err k=%0d", k),  16'(bus1.err),  16'd0);
                check($sformatf("l1 rd_data k=%0d", k), bus1.rd_data, exp_rd);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder serving the MEM-stage load/store request port. It replaces the single-cycle data memory behind that port. It accepts one word request at a time, holds the requestor with a stall for a fixed latency, then returns a one-cycle done pulse with read data or an alignment error. Storage is an internal word array of 2^ADDR_BITS 16-bit words, byte-addressed and word-aligned.

Parameters:
ADDR_BITS, 8, log2 of word depth; word index = req_addr[ADDR_BITS:1], higher address bits ignored (wrap).
LATENCY, 4, cycles from request acceptance to done; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  reset, synchronous, active-high.
req_en  input  1  request valid (requestor drives mem_read|mem_write).
req_wr  input  1  1 = store, 0 = load.
req_addr  input  16  byte address (EX result).
req_data  input  16  store data.
stall  output  1  requestor must hold pipeline/request.
done  output  1  one-cycle completion pulse.
rd_data  output  16  load data, valid only while done=1 and err=0.
err  output  1  misaligned access, pulses with done.

Behaviour:
- States: IDLE, BUSY, RESP. 4-bit down-counter cnt. Latched registers: addr_q, data_q, wr_q, mis_q.
- Reset (sync, rst=1 at edge): state to IDLE, cnt to 0, done to 0, err to 0, rd_data to 0.
  - Pending request discarded; no write commit.
  - Array contents are not cleared.
  - Reset mid-BUSY aborts cleanly.
- Acceptance: a request is accepted in any cycle where state is IDLE or RESP and req_en=1 (call it cycle T).
  - At the T edge: latch addr/data/wr.
  - mis_q = req_addr[0].
- Transitions at the T edge:
  - Misaligned: to RESP.
  - Aligned, LATENCY=1: to RESP.
  - Aligned, LATENCY>1: to BUSY, cnt = LATENCY-2.
- BUSY: if cnt=0, next state is RESP; else cnt decrements. Inputs are ignored in BUSY; only latched values are used.
- RESP (one cycle):
  - done=1.
  - err=mis_q.
  - rd_data = array[addr_q] for an aligned load; 0 for a store or error.
  - From RESP, next state is IDLE, unless a new request is accepted in that same cycle (back-to-back; follows the acceptance rules).
- Timing: done rises at T+LATENCY for aligned requests and at T+1 for misaligned, regardless of LATENCY.
- Store commit: the array is written on the edge entering RESP, i.e. end of cycle T+LATENCY-1.
  - A load accepted in the RESP cycle of that store returns the new value.
  - Misaligned stores never write.
- stall (combinational) = (state==BUSY) | ((state==IDLE or RESP) & req_en & next state != RESP).
  - Consequence: stall=1 in cycle T for aligned requests with LATENCY>1.
  - stall=0 in the RESP cycle unless a new multi-cycle request is accepted there.
  - stall=0 in the cycle a misaligned request or a LATENCY=1 request is accepted.
- done, err and rd_data are registered. rd_data holds its last value outside RESP but is only defined while done=1.
- Address wrap: addr 0x0200 with ADDR_BITS=8 aliases word 0.
- Simultaneous rst and req_en: reset wins; the request is not accepted.

Test Plan:
1. Store then load, LATENCY=4:
   - Store 0xBEEF to addr 0x0010 at T=10 (req_en/req_wr/req_addr/req_data held while stall=1).
   - Required: stall=1 for cycles 10–13, done=1 at cycle 14, err=0, rd_data=0.
   - Then load 0x0010 at T=15 -> done at cycle 19 with rd_data=0xBEEF.
2. Back-to-back store then load: present a load of 0x0010 in the store's RESP cycle -> accepted, done 4 cycles later with the just-stored value 0xBEEF.
3. Misaligned access:
   - Load addr 0x0011 -> stall=0, next cycle done=1, err=1, rd_data=0.
   - Misaligned store 0x0011, data 0x1234 -> word 0x0010 still reads 0xBEEF.
4. Reset mid-operation: store 0x5555 to 0x0020 (word previously 0xAAAA), assert rst for 1 cycle at T+2 -> state IDLE, stall=0, no done pulse, word 0x0020 still reads 0xAAAA.
5. Address wrap: store 0x1357 to 0x0002, load 0x0202 -> rd_data=0x1357.
6. LATENCY=1 build: alternating store/load stream every cycle -> done every cycle, stall never asserted, load data equals the preceding store.
